// File: rtl/mult_div_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
//   MD_* op codes   : operation encodings carried on the op bus (6/7 reserved)
//   md_state_e      : IDLE -> CALC -> FIX sequencing states
//   md_ctrl_t       : per-operation control latched when an op is accepted
package mult_div_unit_pkg;

  localparam int unsigned MD_WORD_LEN_DEF = 32;
  localparam int unsigned MD_OP_LEN_DEF   = 3;

  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MTHI  = 4;
  localparam int unsigned MD_MTLO  = 5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic is_div;    // divide (1) or multiply (0)
    logic neg_res;   // negate product / quotient at the end
    logic neg_rem;   // negate remainder (dividend was negative)
    logic div_zero;  // divisor was zero
  } md_ctrl_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bus between the EXE stage and the multiply/divide unit.
//   master : pipeline side, drives op_valid/op/val1/val2/flush
//   slave  : unit side, drives busy/done/hi/lo
interface mult_div_unit_if #(
  parameter int unsigned WORD_LEN  = mult_div_unit_pkg::MD_WORD_LEN_DEF,
  parameter int unsigned MD_OP_LEN = mult_div_unit_pkg::MD_OP_LEN_DEF
) ();

  logic                 op_valid;
  logic [MD_OP_LEN-1:0] op;
  logic [WORD_LEN-1:0]  val1;
  logic [WORD_LEN-1:0]  val2;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [WORD_LEN-1:0]  hi;
  logic [WORD_LEN-1:0]  lo;

  modport master (
    output op_valid, op, val1, val2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, val1, val2, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_md_iter_step.sv
// Combinational single iteration of the multiply/divide datapath, MSB first.
//   mode      : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in    : product accumulator (mult) / remainder in low WORD_LEN+1 bits (div)
//   shreg_in  : multiplier (mult) / dividend shifting into quotient (div)
//   operand   : multiplicand (mult) / divisor (div)
//   acc_out, shreg_out : values after this step
module md_iter_step #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                  mode,
  input  logic [2*WORD_LEN-1:0] acc_in,
  input  logic [WORD_LEN-1:0]   shreg_in,
  input  logic [WORD_LEN-1:0]   operand,
  output logic [2*WORD_LEN-1:0] acc_out,
  output logic [WORD_LEN-1:0]   shreg_out
);

  localparam int unsigned ACC_W = 2 * WORD_LEN;

  logic [ACC_W-1:0]  mul_acc;
  logic [WORD_LEN:0] rem_sh;
  logic [WORD_LEN:0] divisor_ext;
  logic [WORD_LEN:0] rem_new;
  logic              q_bit;

  // Multiply: acc = 2*acc + (next multiplier bit ? multiplicand : 0)
  assign mul_acc = {acc_in[ACC_W-2:0], 1'b0}
                 + (shreg_in[WORD_LEN-1] ? {{WORD_LEN{1'b0}}, operand} : '0);

  // Divide: bring in next dividend bit, subtract divisor if it fits
  assign rem_sh      = {acc_in[WORD_LEN-1:0], shreg_in[WORD_LEN-1]};
  assign divisor_ext = {1'b0, operand};
  assign q_bit       = (rem_sh >= divisor_ext);
  assign rem_new     = q_bit ? (rem_sh - divisor_ext) : rem_sh;

  always_comb begin
    if (mode) begin
      acc_out   = {{(WORD_LEN-1){1'b0}}, rem_new};
      shreg_out = {shreg_in[WORD_LEN-2:0], q_bit};
    end else begin
      acc_out   = mul_acc;
      shreg_out = {shreg_in[WORD_LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, plus MTHI/MTLO.
//   clock, reset : system clock, synchronous active-high reset
//   md (slave)   : op_valid/op/val1/val2/flush in; busy/done/hi/lo out
// An accepted mult/div takes WORD_LEN+1 cycles; done pulses for one cycle with
// the new HI/LO and busy already low, so a follow-on op can issue that cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WORD_LEN  = MD_WORD_LEN_DEF,
  parameter int unsigned MD_OP_LEN = MD_OP_LEN_DEF
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_unit_if.slave md
);

  localparam int unsigned CNT_W = $clog2(WORD_LEN);
  localparam int unsigned ACC_W = 2 * WORD_LEN;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WORD_LEN-1:0] shreg_q, shreg_d;
  logic [WORD_LEN-1:0] operand_q, operand_d;
  md_ctrl_t            ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_LEN-1:0] hi_q, hi_d;
  logic [WORD_LEN-1:0] lo_q, lo_d;

  logic                accept_c, start_c, is_mul_c, is_div_c, signed_c;
  logic                is_mthi_c, is_mtlo_c;
  logic                sign1_c, sign2_c;
  logic [WORD_LEN-1:0] mag1_c, mag2_c;
  logic [ACC_W-1:0]    step_acc_c;
  logic [WORD_LEN-1:0] step_shreg_c;
  logic [ACC_W-1:0]    product_c;
  logic [WORD_LEN-1:0] quot_c, rem_c;

  // Op decode and acceptance
  assign accept_c  = md.op_valid && !busy_q && !md.flush;
  assign is_mul_c  = (md.op == MD_OP_LEN'(MD_MULT)) || (md.op == MD_OP_LEN'(MD_MULTU));
  assign is_div_c  = (md.op == MD_OP_LEN'(MD_DIV))  || (md.op == MD_OP_LEN'(MD_DIVU));
  assign signed_c  = (md.op == MD_OP_LEN'(MD_MULT)) || (md.op == MD_OP_LEN'(MD_DIV));
  assign is_mthi_c = (md.op == MD_OP_LEN'(MD_MTHI));
  assign is_mtlo_c = (md.op == MD_OP_LEN'(MD_MTLO));
  assign start_c   = accept_c && (is_mul_c || is_div_c);

  // Operand magnitudes; unsigned ops pass raw values
  assign sign1_c = signed_c && md.val1[WORD_LEN-1];
  assign sign2_c = signed_c && md.val2[WORD_LEN-1];
  assign mag1_c  = sign1_c ? -md.val1 : md.val1;
  assign mag2_c  = sign2_c ? -md.val2 : md.val2;

  md_iter_step #(.WORD_LEN(WORD_LEN)) u_step (
    .mode      (ctrl_q.is_div),
    .acc_in    (acc_q),
    .shreg_in  (shreg_q),
    .operand   (operand_q),
    .acc_out   (step_acc_c),
    .shreg_out (step_shreg_c)
  );

  // Sign correction. A zero divisor leaves rem = |val1|, so restoring its sign
  // gives back val1 unchanged; only the quotient needs forcing to all ones.
  assign product_c = ctrl_q.neg_res ? -acc_q : acc_q;
  assign quot_c    = ctrl_q.div_zero ? '1
                   : (ctrl_q.neg_res ? -shreg_q : shreg_q);
  assign rem_c     = ctrl_q.neg_rem ? -acc_q[WORD_LEN-1:0] : acc_q[WORD_LEN-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_c) state_d = MD_CALC;
      MD_CALC: begin
        if (md.flush)                            state_d = MD_IDLE;
        else if (cnt_q == CNT_W'(WORD_LEN - 1))  state_d = MD_FIX;
      end
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    operand_d = operand_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (accept_c && is_mthi_c) hi_d = md.val1;
        if (accept_c && is_mtlo_c) lo_d = md.val1;
        if (start_c) begin
          busy_d          = 1'b1;
          cnt_d           = '0;
          acc_d           = '0;
          shreg_d         = mag1_c;
          operand_d       = mag2_c;
          ctrl_d.is_div   = is_div_c;
          ctrl_d.neg_res  = sign1_c ^ sign2_c;
          ctrl_d.neg_rem  = is_div_c && sign1_c;
          ctrl_d.div_zero = is_div_c && (md.val2 == '0);
        end
      end
      MD_CALC: begin
        if (md.flush) begin
          busy_d = 1'b0;
        end else begin
          acc_d   = step_acc_c;
          shreg_d = step_shreg_c;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      MD_FIX: begin
        busy_d = 1'b0;
        if (!md.flush) begin
          done_d = 1'b1;
          if (ctrl_q.is_div) begin
            hi_d = rem_c;
            lo_d = quot_c;
          end else begin
            hi_d = product_c[ACC_W-1:WORD_LEN];
            lo_d = product_c[WORD_LEN-1:0];
          end
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      operand_q <= '0;
      ctrl_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      operand_q <= operand_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, boundary
// divides, flush, busy rejection, back-to-back issue and mid-operation reset.
module tb_mult_div_unit;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   nbusy;
  bit   seen;

  mult_div_unit_if #(.WORD_LEN(32), .MD_OP_LEN(3)) md_bus ();

  mult_div_unit #(.WORD_LEN(32), .MD_OP_LEN(3)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md_bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; op is presented and accepted at the next posedge
  task automatic issue(input logic [2:0] op, input logic [31:0] v1, input logic [31:0] v2);
    md_bus.op_valid = 1'b1;
    md_bus.op       = op;
    md_bus.val1     = v1;
    md_bus.val2     = v2;
    @(posedge clock);
    #1 md_bus.op_valid = 1'b0;
  endtask

  // Returns at the negedge where done is seen, counting busy cycles before it
  task automatic wait_done(output int nb, output bit sn);
    nb = 0;
    sn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (md_bus.done === 1'b1) begin
        sn = 1'b1;
        break;
      end
      if (md_bus.busy === 1'b1) nb++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clock);
    issue(op, v1, v2);
    wait_done(nbusy, seen);
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy0"}, 32'(md_bus.busy), 32'd0);
    check({tag, "_hi"}, md_bus.hi, exp_hi);
    check({tag, "_lo"}, md_bus.lo, exp_lo);
  endtask

  initial begin
    reset           = 1'b1;
    md_bus.op_valid = 1'b0;
    md_bus.op       = 3'd0;
    md_bus.val1     = 32'd0;
    md_bus.val2     = 32'd0;
    md_bus.flush    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_hi", md_bus.hi, 32'd0);
    check("rst_lo", md_bus.lo, 32'd0);
    check("rst_busy", 32'(md_bus.busy), 32'd0);
    check("rst_done", 32'(md_bus.done), 32'd0);
    reset = 1'b0;

    // MULT -3 * 5, with latency and one-cycle done pulse
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check("mult_neg_busy_cycles", 32'(nbusy), 32'd33);
    @(negedge clock);
    check("mult_neg_done_pulse", 32'(md_bus.done), 32'd0);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    check("divu_busy_cycles", 32'(nbusy), 32'd33);
    run_op("divu_by0", 3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Reserved op code changes nothing
    @(negedge clock);
    issue(3'd6, 32'h0000_0077, 32'd3);
    @(negedge clock);
    check("rsvd_busy", 32'(md_bus.busy), 32'd0);
    check("rsvd_hi", md_bus.hi, 32'hFFFF_FFF0);
    check("rsvd_lo", md_bus.lo, 32'hFFFF_FFFF);

    // Preload HI/LO
    issue(3'd4, 32'h0000_AAAA, 32'd0);
    @(negedge clock);
    check("mthi_busy", 32'(md_bus.busy), 32'd0);
    issue(3'd5, 32'h0000_5555, 32'd0);
    @(negedge clock);
    check("mthi_hi", md_bus.hi, 32'h0000_AAAA);
    check("mtlo_lo", md_bus.lo, 32'h0000_5555);
    check("mtlo_done", 32'(md_bus.done), 32'd0);

    // Flush in IDLE blocks acceptance
    md_bus.flush = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    md_bus.flush = 1'b0;
    @(negedge clock);
    check("flush_idle_busy", 32'(md_bus.busy), 32'd0);

    // Flush mid-CALC
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(negedge clock);
    check("flush_pre_busy", 32'(md_bus.busy), 32'd1);
    md_bus.flush = 1'b1;
    @(posedge clock);
    #1 md_bus.flush = 1'b0;
    @(negedge clock);
    check("flush_busy", 32'(md_bus.busy), 32'd0);
    wait_done(nbusy, seen);
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_hi", md_bus.hi, 32'h0000_AAAA);
    check("flush_lo", md_bus.lo, 32'h0000_5555);

    // MTHI while busy is dropped
    @(negedge clock);
    issue(3'd0, 32'd3, 32'd4);
    repeat (4) @(negedge clock);
    issue(3'd4, 32'h0000_DEAD, 32'd0);
    @(negedge clock);
    check("busy_mthi_hi", md_bus.hi, 32'h0000_AAAA);
    wait_done(nbusy, seen);
    check("busy_mthi_done", 32'(seen), 32'd1);
    check("busy_mthi_res_hi", md_bus.hi, 32'd0);
    check("busy_mthi_res_lo", md_bus.lo, 32'd12);

    // Back-to-back: second op issued in the done cycle of the first
    run_op("b2b_first", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6);
    issue(3'd0, 32'd2, 32'd2);
    wait_done(nbusy, seen);
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_second_busy", 32'(nbusy), 32'd33);
    check("b2b_second_lo", md_bus.lo, 32'd4);
    check("b2b_second_hi", md_bus.hi, 32'd0);

    // Reset mid-CALC
    @(negedge clock);
    issue(3'd1, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrst_hi", md_bus.hi, 32'd0);
    check("midrst_lo", md_bus.lo, 32'd0);
    check("midrst_busy", 32'(md_bus.busy), 32'd0);
    check("midrst_done", 32'(md_bus.done), 32'd0);
    wait_done(nbusy, seen);
    check("midrst_no_done", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers for the MIPS pipeline.
- Sits beside the EXE-stage ALU and executes MULT/MULTU/DIV/DIVU over several cycles, plus single-cycle MTHI/MTLO.
- Exposes `busy` so hazard logic stalls issue.
- Provides HI/LO read-out for MFHI/MFLO.

Parameters:
- WORD_LEN, 32, operand and HI/LO width; must be even and >= 4.
- MD_OP_LEN, 3, width of the op code.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  op/val1/val2 valid this cycle
- op  in  MD_OP_LEN  operation code (encodings in defines.v)
- val1  in  WORD_LEN  rs operand: multiplicand / dividend / MTHI-MTLO source
- val2  in  WORD_LEN  rt operand: multiplier / divisor
- flush  in  1  abort in-flight operation (branch/exception squash)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: HI/LO hold a new mult/div result
- hi  out  WORD_LEN  HI register (MFHI source)
- lo  out  WORD_LEN  LO register (MFLO source)

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high. All state changes occur on the rising edge of `clock`.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Op codes:
  - MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - Codes 6 and 7 are reserved; they are ignored and change no state.
- Acceptance: an op is accepted only at an edge where op_valid=1, busy=0 and flush=0. Otherwise it is dropped. The pipeline must stall on busy.
- MTHI/MTLO: hi (or lo) <= val1 at the accepting edge. No busy, no done.
- State machine: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: on an accepted mult/div op:
    - latch |val1| and |val2| (signed ops) or the raw values (unsigned ops);
    - latch the result sign and the op;
    - clear the counter; go to CALC.
  - CALC: one shift-add (mult) or restoring-subtract (div) step per cycle for exactly WORD_LEN cycles. The counter runs 0..WORD_LEN-1. Then go to FIX.
  - FIX: apply sign correction; write hi/lo; go to IDLE.
- Timing:
  - Accept at edge 0.
  - busy is high from after edge 0 until edge WORD_LEN+1.
  - hi/lo update at edge WORD_LEN+1. done=1 for exactly the following cycle, and busy=0 in that same cycle.
  - Latency is WORD_LEN+1 cycles (33 at default).
  - A new op may be accepted in the cycle done is high.
- Multiply: the 2*WORD_LEN-bit product goes to {hi,lo}. The signed product is two's-complement negated when the operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (val2=0, DIV or DIVU): lo = all ones, hi = val1 unchanged. Normal latency and done still apply.
- Signed overflow (DIV of the most negative value by -1): lo = most negative value, hi = 0.
- flush:
  - In CALC or FIX: returns to IDLE at the next edge. hi/lo are unchanged, no done pulse, busy=0 the next cycle.
  - In IDLE: blocks acceptance that edge.
- reset mid-operation: same as the reset values. The in-flight result is discarded.
- Internal datapath width: the accumulator/remainder is WORD_LEN+1 bits for div and 2*WORD_LEN bits for mult.

Decomposition:
- defines.v (shared): MD_OP_LEN, the MD_* op codes, and MD state encodings (IDLE=0, CALC=1, FIX=2).
- WORD_LEN stays a module parameter, with the `WORD_LEN define used as the default.
- One natural sub-module: md_iter_step.
  - Combinational single-iteration datapath: a shift-add step or a restoring-subtract step, selected by a mode bit.
  - Instanced once.
  - Sign handling and the FSM stay in mult_div_unit.

Test Plan:
- MULT val1=0xFFFFFFFD (-3), val2=5 -> after 33 cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU val1=val2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV val1=0xFFFFFFF9 (-7), val2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- Boundary divides:
  - DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flush and busy rejection:
  - Preload MTHI 0xAAAA and MTLO 0x5555.
  - Start MULT 3*4; assert flush at cycle 10 -> busy drops next cycle, no done, hi=0xAAAA, lo=0x5555.
  - MTHI issued while busy -> ignored.
- Back-to-back and reset:
  - Issue the second MULT 2*2 in the done cycle of the first -> accepted; second done 33 cycles later with lo=4.
  - Assert reset mid-CALC -> all outputs 0 next cycle.
